// File: rtl/gamepad_pkg.sv
// Shared definitions for the serial gamepad reader: FSM states, pad button
// layout and a width helper for small index counters.
package gamepad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_GAP,
      ST_CLK_HIGH,
      ST_CLK_LOW,
      ST_DONE
   } state_t;

   localparam int PAD_BUTTON_COUNT = 12;

   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // A one-entry range still needs a one-bit counter.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gamepad_reader_tick_gen.sv
// Phase timer for the pad reader: down-counter reloaded on each FSM state
// entry, flags the last cycle of a CLK_DIV or 2*CLK_DIV long phase.
module gamepad_tick_gen
   import gamepad_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic reload,
   input  logic long_phase,
   output logic phase_end
);

   localparam int TC_W = $clog2(2 * CLK_DIV);
   localparam logic [TC_W-1:0] SHORT_LOAD = TC_W'(CLK_DIV - 1);
   localparam logic [TC_W-1:0] LONG_LOAD  = TC_W'(2 * CLK_DIV - 1);

   logic [TC_W-1:0] tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tc <= '0;
      end else if (reload) begin
         tc <= long_phase ? LONG_LOAD : SHORT_LOAD;
      end else if (tc != '0) begin
         tc <= tc - 1'b1;
      end
   end

   assign phase_end = (tc == '0);

endmodule

// File: rtl/gamepad_reader.sv
// Host-side serial gamepad reader: latches one or two pads, clocks out
// BUTTON_COUNT bits each and publishes them atomically with a valid pulse.
//
// state    | meaning
// IDLE     | lines low, waiting for start
// LATCH    | latch strobe phase, 2*CLK_DIV cycles
// GAP      | latch low, bit 0 sampled on last cycle
// CLK_HIGH | shift clock high phase
// CLK_LOW  | shift clock low phase, bit bi sampled on last cycle
// DONE     | copy shift-in registers to outputs, pulse valid
module gamepad_reader
   import gamepad_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int BUTTON_COUNT = 12,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [1:0]              pad_out,
   output logic                    pad_latch,
   output logic                    pad_clk,
   output logic [BUTTON_COUNT-1:0] p1_btn,
   output logic [BUTTON_COUNT-1:0] p2_btn,
   output logic                    busy,
   output logic                    valid
);

   localparam int BI_W = idx_width(BUTTON_COUNT);
   localparam logic [BI_W-1:0] LAST_BI = BI_W'(BUTTON_COUNT - 1);
   localparam logic [BUTTON_COUNT-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

   state_t state, next_state;
   logic   reload, long_phase, phase_end;
   logic   sample, bi_clr, bi_inc;
   logic [BI_W-1:0]         bi;
   logic [BUTTON_COUNT-1:0] shift_p1, shift_p2;

   gamepad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk        (clk),
      .reset      (reset),
      .reload     (reload),
      .long_phase (long_phase),
      .phase_end  (phase_end)
   );

   always_comb begin
      next_state = state;
      reload     = 1'b0;
      long_phase = 1'b0;
      sample     = 1'b0;
      bi_clr     = 1'b0;
      bi_inc     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_LATCH;
               reload     = 1'b1;
               long_phase = 1'b1;
               bi_clr     = 1'b1;
            end
         end
         ST_LATCH: begin
            if (phase_end) begin
               next_state = ST_GAP;
               reload     = 1'b1;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               sample = 1'b1;
               if (BUTTON_COUNT == 1) begin
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_CLK_HIGH;
                  reload     = 1'b1;
                  bi_inc     = 1'b1;
               end
            end
         end
         ST_CLK_HIGH: begin
            if (phase_end) begin
               next_state = ST_CLK_LOW;
               reload     = 1'b1;
            end
         end
         ST_CLK_LOW: begin
            if (phase_end) begin
               sample = 1'b1;
               if (bi == LAST_BI) begin
                  next_state = ST_DONE;
               end else begin
                  next_state = ST_CLK_HIGH;
                  reload     = 1'b1;
                  bi_inc     = 1'b1;
               end
            end
         end
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         bi       <= '0;
         shift_p1 <= '0;
         shift_p2 <= '0;
      end else begin
         state <= next_state;
         if (bi_clr) begin
            bi <= '0;
         end else if (bi_inc) begin
            bi <= bi + 1'b1;
         end
         if (sample) begin
            shift_p1[bi] <= pad_out[0];
            shift_p2[bi] <= pad_out[1];
         end
      end
   end

   // pad_clk follows next_state so each sample lands a full CLK_DIV after the fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_latch <= 1'b0;
         pad_clk   <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         p1_btn    <= '0;
         p2_btn    <= '0;
      end else begin
         pad_latch <= (state == ST_LATCH);
         pad_clk   <= (next_state == ST_CLK_HIGH);
         busy      <= (next_state != ST_IDLE);
         valid     <= (state == ST_DONE);
         if (state == ST_DONE) begin
            p1_btn <= shift_p1 ^ POL_MASK;
            p2_btn <= shift_p2 ^ POL_MASK;
         end
      end
   end

endmodule
